// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared audio definitions for the I2S playback and capture paths.
//   AUDIO_SAMPLE_W  : width of one PCM sample
//   I2S_SLOT_W      : BCK periods per channel slot
//   I2S_FRAME_BITS  : BCK periods per stereo frame
//   stereo_sample_t : one left/right sample pair
//   nco_increment() : phase increment for an NCO that must tick 128 times per
//                     sample period (two BCK edges per bit, 64 bits per frame)
// -----------------------------------------------------------------------------
package audio_pkg;

    localparam int AUDIO_SAMPLE_W = 16;
    localparam int I2S_SLOT_W     = 32;
    localparam int I2S_FRAME_BITS = 64;

    typedef struct packed {
        logic [AUDIO_SAMPLE_W-1:0] l;
        logic [AUDIO_SAMPLE_W-1:0] r;
    } stereo_sample_t;

    // round(2^acc_w * 128 * sample_rate / clk_hz); the << 7 is the factor 128.
    function automatic logic [63:0] nco_increment(
        input longint unsigned clk_hz,
        input longint unsigned sample_rate,
        input int unsigned     acc_w
    );
        logic [127:0] num;
        logic [127:0] quo;
        num = ((128'd1 << acc_w) * 128'(sample_rate)) << 7;
        num = num + 128'(clk_hz >> 1);
        quo = num / 128'(clk_hz);
        return quo[63:0];
    endfunction

endpackage

// File: rtl/stereo_fifo.sv
// -----------------------------------------------------------------------------
// stereo_fifo
// Synchronous FIFO of stereo sample pairs, async active-high reset.
//   i_clk, i_rst      : clock, asynchronous reset
//   i_push, i_din     : write request and data (ignored while full)
//   i_pop             : read request (ignored while empty)
//   o_dout            : head entry, valid while !o_empty
//   o_full, o_empty   : status from the registered occupancy count
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// -----------------------------------------------------------------------------
module stereo_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_push,
    input  stereo_sample_t i_din,
    input  logic           i_pop,
    output stereo_sample_t o_dout,
    output logic           o_full,
    output logic           o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    stereo_sample_t r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic           w_do_push;
    logic           w_do_pop;

    // Status flags, gated requests and head-of-queue read.
    always_comb begin
        o_full    = (r_count == (AW+1)'(DEPTH));
        o_empty   = (r_count == '0);
        w_do_push = i_push & ~o_full;
        w_do_pop  = i_pop & ~o_empty;
        o_dout    = r_mem[r_rd_ptr];
    end

    // Pointers and occupancy; simultaneous push and pop leaves the count alone.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(32'd1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(32'd1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(32'd1);
                2'b01:   r_count <= r_count - (AW+1)'(32'd1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are only observed through valid occupancy.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// -----------------------------------------------------------------------------
// i2s_tx
// Stereo Philips-I2S master transmitter. Sample pairs are queued in a small
// FIFO; an NCO derives BCK/LRCK from sys_clk and a 64-bit frame serializer
// shifts the pair out MSB first. An empty FIFO at frame start mutes the frame
// and sets the sticky underrun flag.
//   sys_clk, sys_rst          : clock, asynchronous active-high reset
//   enable                    : run the serializer; low holds outputs idle
//   s_valid, s_ready          : sample-pair handshake (s_ready = FIFO not full)
//   s_left, s_right           : 16-bit two's complement samples
//   clear_underrun            : synchronous clear of underrun
//   i2s_bck, i2s_lrck, i2s_dout : I2S bus to the DAC
//   underrun                  : sticky, a frame started with the FIFO empty
// -----------------------------------------------------------------------------
module i2s_tx
    import audio_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int SAMPLE_RATE = 48000,
    parameter int FIFO_DEPTH  = 4,
    parameter int ACC_W       = 32
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      enable,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [AUDIO_SAMPLE_W-1:0] s_left,
    input  logic [AUDIO_SAMPLE_W-1:0] s_right,
    input  logic                      clear_underrun,
    output logic                      i2s_bck,
    output logic                      i2s_lrck,
    output logic                      i2s_dout,
    output logic                      underrun
);

    localparam logic [63:0]      INC_FULL = nco_increment(64'(CLK_HZ), 64'(SAMPLE_RATE), ACC_W);
    localparam logic [ACC_W-1:0] INC      = INC_FULL[ACC_W-1:0];

    logic [ACC_W-1:0] r_acc;
    logic             r_bck;
    logic             r_lrck;
    logic             r_dout;
    logic             r_underrun;
    logic [5:0]       r_bit_cnt;
    stereo_sample_t   r_shadow;

    logic [ACC_W:0]   w_sum;
    logic             w_tick;
    logic             w_fall;
    logic [5:0]       w_bit_cnt_next;
    logic [5:0]       w_slot;
    logic [15:0]      w_word;
    logic             w_bit;
    logic             w_pop;
    logic             w_push;
    stereo_sample_t   w_push_data;
    stereo_sample_t   w_fifo_dout;
    logic             w_fifo_full;
    logic             w_fifo_empty;

    // NCO carry, bit-slot decode and FIFO strobes.
    always_comb begin
        w_sum          = {1'b0, r_acc} + {1'b0, INC};
        w_tick         = enable & w_sum[ACC_W];
        w_fall         = w_tick & r_bck;
        w_bit_cnt_next = r_bit_cnt + 6'd1;
        // The bit emitted for bit_cnt_next belongs to slot bit_cnt_next-1,
        // which is simply the current count: this gives the one-BCK Philips delay.
        w_slot         = r_bit_cnt;
        w_word         = w_slot[5] ? r_shadow.r : r_shadow.l;
        if (w_slot[4] == 1'b0) begin
            w_bit = w_word[4'd15 - w_slot[3:0]];
        end else begin
            w_bit = 1'b0;
        end
        w_pop          = w_fall & (w_bit_cnt_next == 6'd0);
        w_push         = s_valid & ~w_fifo_full;
        w_push_data.l  = s_left;
        w_push_data.r  = s_right;
    end

    // NCO, bit clock, frame counter and serial outputs.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_acc     <= '0;
            r_bck     <= 1'b0;
            r_lrck    <= 1'b0;
            r_dout    <= 1'b0;
            r_bit_cnt <= 6'd63;
        end else if (!enable) begin
            // Idle: parked so the next tick is a rising edge and the first
            // falling edge wraps bit_cnt to 0, starting a fresh frame.
            r_acc     <= '0;
            r_bck     <= 1'b0;
            r_lrck    <= 1'b0;
            r_dout    <= 1'b0;
            r_bit_cnt <= 6'd63;
        end else begin
            r_acc <= w_sum[ACC_W-1:0];
            if (w_tick) begin
                r_bck <= ~r_bck;
                if (r_bck) begin
                    r_bit_cnt <= w_bit_cnt_next;
                    r_lrck    <= w_bit_cnt_next[5];
                    r_dout    <= w_bit;
                end
            end
        end
    end

    // Frame shadow load and sticky underrun; a new underrun beats a clear.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_shadow   <= '0;
            r_underrun <= 1'b0;
        end else begin
            if (w_pop) begin
                r_shadow <= w_fifo_empty ? '0 : w_fifo_dout;
            end
            if (w_pop && w_fifo_empty) begin
                r_underrun <= 1'b1;
            end else if (clear_underrun) begin
                r_underrun <= 1'b0;
            end
        end
    end

    stereo_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (sys_clk),
        .i_rst   (sys_rst),
        .i_push  (w_push),
        .i_din   (w_push_data),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign s_ready  = ~w_fifo_full;
    assign i2s_bck  = r_bck;
    assign i2s_lrck = r_lrck;
    assign i2s_dout = r_dout;
    assign underrun = r_underrun;

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Stereo I2S master transmitter for the audio playback path, the transmit counterpart of the existing PCM1808 I2S receive chain. It accepts 16-bit left/right sample pairs over a valid/ready handshake into a small FIFO. It generates its own BCK/LRCK from `sys_clk` using a phase-accumulator (NCO) divider, and serializes Philips-format I2S to an external DAC. On FIFO underrun it mutes (sends zeros) and raises a sticky flag.

## Interface
Parameters:
- `CLK_HZ`, default 50_000_000: `sys_clk` frequency.
- `SAMPLE_RATE`, default 48000: target Fs. BCK = 64·Fs.
- `FIFO_DEPTH`, default 4: sample-pair entries. Must be a power of 2 and ≥2.
- `ACC_W`, default 32: NCO accumulator width.

Ports:
- `sys_clk` in 1: system clock.
- `sys_rst` in 1: reset, asynchronous, active-high.
- `enable` in 1: run the serializer. When low, the outputs are held idle.
- `s_valid` in 1: sample pair valid.
- `s_ready` out 1: FIFO not full.
- `s_left` in 16: left sample, two's complement.
- `s_right` in 16: right sample, two's complement.
- `clear_underrun` in 1: synchronous clear of `underrun`.
- `i2s_bck` out 1: bit clock to the DAC.
- `i2s_lrck` out 1: word select. 0 = left, 1 = right.
- `i2s_dout` out 1: serial data, MSB first.
- `underrun` out 1: sticky. A frame started with the FIFO empty.

## Operation
- **NCO**
  - `INC = round(2^ACC_W · 128·SAMPLE_RATE / CLK_HZ)`. Default value: 527765581.
  - Each cycle with `enable`=1: `acc <= acc + INC` (modulo 2^ACC_W).
  - `tick` = the carry out of that add.
  - Each `tick` toggles `i2s_bck`.
- **Frame**
  - 64 BCK periods per frame. 6-bit `bit_cnt` advances on every falling-edge tick (BCK 1→0) and wraps 63→0.
  - On the same falling edge:
    - `i2s_lrck <= bit_cnt_next[5]`.
    - `i2s_dout <= shadow[(bit_cnt_next-1) mod 64]`, with slot mapping: slot `s = (bit_cnt_next-1) mod 64`, channel = `s[5]`, `idx = s[4:0]`. Output the channel word bit `15-idx` if `idx<16`, else 0.
  - Result: the MSB appears one BCK after the LRCK edge (Philips). Bits 16..31 of each slot are zero padding.
- **Frame load**
  - On the falling edge where `bit_cnt_next`=0, pop one FIFO entry into the 32-bit shadow register.
  - If the FIFO is empty, load 0 and set `underrun`.
  - The popped word drives slots starting at `bit_cnt`=1. The right slot's last bit (`bit_cnt`=0 of the next frame) is padding.
- **FIFO**
  - Push when `s_valid && s_ready`.
  - `s_ready = !full`, from registered occupancy. A push is not accepted in the same cycle as a pop while full.
  - Simultaneous push and pop when neither full nor empty: occupancy is unchanged.
- **Disable** (`enable`=0):
  - `acc`=0, `i2s_bck`=0, `i2s_lrck`=0, `i2s_dout`=0, `bit_cnt`=63.
  - Shadow is held, and the FIFO still accepts pushes.
  - On re-enable, the first tick is a rising edge. The first falling edge starts frame 0.
- **Underrun flag**
  - `underrun` set has priority over `clear_underrun` in the same cycle.

## Timing
- Reset values:
  - `i2s_bck`=0, `i2s_lrck`=0, `i2s_dout`=0, `underrun`=0.
  - `s_ready`=1 (FIFO emptied), shadow=0, `acc`=0, `bit_cnt`=63.
- Outputs are registered and update in the cycle in which `tick` is asserted. They never change on a non-tick cycle.
- BCK half-period is ⌊CLK_HZ/(128·Fs)⌋ or ⌈CLK_HZ/(128·Fs)⌉ cycles, i.e. 8 or 9 cycles at defaults. The long-run mean is exact to NCO resolution.
- Latency:
  - A pair pushed while idle and enabled appears as the left MSB on `i2s_dout` at the first frame boundary after the push, plus 1 BCK.
  - The worst case is one frame plus 1 BCK.
- Data changes only on BCK falling edges. The DAC samples on rising edges, giving a half-BCK setup.
- Asserting `sys_rst` mid-frame forces all outputs to their reset values immediately. The partial frame and FIFO contents are discarded.

## Structure
- Shared `audio_pkg`:
  - `AUDIO_SAMPLE_W=16`, `I2S_SLOT_W=32`, `I2S_FRAME_BITS=64`.
  - `typedef struct packed {logic [15:0] l; logic [15:0] r;} stereo_sample_t`.
  - A function computing the NCO increment from `CLK_HZ`/`SAMPLE_RATE`, shareable with future clock generators.
- One sub-module: `stereo_fifo`, a synchronous FIFO of `stereo_sample_t` with push/pop/full/empty and async reset.
- NCO, bit counter and serializer live in `i2s_tx`.

## Test plan
- **Reset:** assert `sys_rst` → all outputs 0, `s_ready`=1, `underrun`=0. Hold `enable`=1 for 100 cycles with no push → BCK toggles, `i2s_dout` stays 0, `underrun`=1 after the first frame load.
- **Single pair:** push L=0xA5C3, R=0x5A3C, `enable`=1. A bench I2S receiver sampling on BCK rising edges decodes left=0xA5C3 and right=0x5A3C. Padding bits are all 0, and the MSB lags the LRCK edge by exactly 1 BCK.
- **FIFO full:** `enable`=0, push 4 pairs (0x0001/0x8001 … 0x0004/0x8004) → `s_ready`=0 after the 4th, and a 5th `s_valid` is held off. Then `enable`=1 → pairs emerge in order, `s_ready` returns to 1 after the first pop, and the 5th pair follows.
- **Underrun/clear:** stream 3 pairs then stop → the 4th frame is zeros and `underrun`=1. Pulse `clear_underrun` → 0, then re-set on the next empty frame load. Simultaneous set and clear → remains 1.
- **Rate:** 10^6 cycles with `enable`=1 → 960 ±1 LRCK rising edges. Every BCK high/low interval is 8 or 9 cycles, and LRCK toggles only on BCK falling edges.
- **Reset mid-frame:** assert `sys_rst` at `bit_cnt`≈20 with 2 pairs queued → outputs 0 in the same cycle. After release and re-enable, the first frame is muted and `underrun`=1.
